// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared state encoding and sizing helpers for the instruction memory loader
package instr_mem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

  // Index width for a power-of-two depth; never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/instr_mem_ram.sv
// rtl/instr_mem_ram.sv - simple dual-port RAM, synchronous write and synchronous read
module instr_mem_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned IDX_W  = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  // No reset on the array or read register so the tools can map it to block RAM.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - sequentially loaded instruction memory with counter-based clear and checked fetch
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 1024,
  parameter bit                BYTE_ADDR = 1'b0,
  parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(DEFAULT_NOP_WORD)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        wr_valid,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        wr_ready,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           addr,
  output logic [DATA_W-1:0]           instruction,
  output logic                        instr_valid,
  output logic                        addr_err,
  output logic [idx_width(DEPTH):0]   count,
  output logic                        full,
  output logic                        wr_ovf,
  output logic                        busy
);

  localparam int unsigned IDX_W     = idx_width(DEPTH);
  localparam int unsigned IDX_SHIFT = BYTE_ADDR ? 2 : 0;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
  logic [IDX_W:0]     count_q, count_d;
  logic               wr_ovf_q, wr_ovf_d;
  logic               fetch_vld_q, fetch_vld_d;
  logic               fetch_err_q, fetch_err_d;

  logic               ram_we;
  logic [IDX_W-1:0]   ram_waddr;
  logic [DATA_W-1:0]  ram_wdata;
  logic               ram_re;
  logic [DATA_W-1:0]  ram_rdata;

  logic [IDX_W-1:0]   wr_ptr;
  logic [IDX_W-1:0]   fetch_idx;
  logic               addr_hi_bad;
  logic               addr_misaligned;
  logic               idx_bad;
  logic               fetch_bad;

  // Appends never wrap, so the write pointer is simply the low bits of the fill count.
  assign wr_ptr = count_q[IDX_W-1:0];
  assign full   = (count_q == (IDX_W+1)'(DEPTH));

  assign fetch_idx       = IDX_W'(addr >> IDX_SHIFT);
  assign addr_hi_bad     = |(addr >> (IDX_SHIFT + IDX_W));
  assign addr_misaligned = BYTE_ADDR && (addr[1:0] != 2'b00);
  assign idx_bad         = ({1'b0, fetch_idx} >= count_q);
  assign fetch_bad       = addr_hi_bad || addr_misaligned || idx_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_CLEAR;
      clr_idx_q   <= '0;
      count_q     <= '0;
      wr_ovf_q    <= 1'b0;
      fetch_vld_q <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      count_q     <= count_d;
      wr_ovf_q    <= wr_ovf_d;
      fetch_vld_q <= fetch_vld_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    count_d     = count_q;
    wr_ovf_d    = wr_ovf_q;
    fetch_vld_d = 1'b0;
    fetch_err_d = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = clr_idx_q;
    ram_wdata   = NOP_WORD;
    ram_re      = 1'b0;

    if (clr) begin
      // Soft clear wins over start and any write handshake this cycle.
      state_d   = ST_CLEAR;
      clr_idx_d = '0;
      count_d   = '0;
      wr_ovf_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_CLEAR: begin
          ram_we    = 1'b1;
          ram_waddr = clr_idx_q;
          ram_wdata = NOP_WORD;
          if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
            state_d   = ST_LOAD;
            clr_idx_d = '0;
          end else begin
            clr_idx_d = clr_idx_q + 1'b1;
          end
        end
        ST_LOAD: begin
          if (wr_valid && !full) begin
            ram_we    = 1'b1;
            ram_waddr = wr_ptr;
            ram_wdata = wr_data;
            count_d   = count_q + 1'b1;
          end
          if (wr_valid && full) begin
            wr_ovf_d = 1'b1;
          end
          if (start) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          ram_re      = 1'b1;
          fetch_vld_d = 1'b1;
          fetch_err_d = fetch_bad;
          if (!start) begin
            state_d = ST_LOAD;
          end
        end
        default: begin
          state_d = ST_CLEAR;
        end
      endcase
    end
  end

  instr_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (fetch_idx),
    .rdata_o (ram_rdata)
  );

  // The RAM read register is not reset; the registered flags mask it to NOP_WORD.
  assign instruction = (fetch_vld_q && !fetch_err_q) ? ram_rdata : NOP_WORD;
  assign instr_valid = fetch_vld_q;
  assign addr_err    = fetch_err_q;
  assign count       = count_q;
  assign wr_ovf      = wr_ovf_q;
  assign busy        = (state_q == ST_CLEAR);
  assign wr_ready    = (state_q == ST_LOAD) && !full;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - self-checking bench for word- and byte-addressed instruction memory loaders
module tb_instr_mem_loader;

  localparam int          DEPTH = 8;
  localparam logic [31:0] NOP_W = 32'h0000_0000;
  localparam logic [31:0] NOP_B = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, clr, wr_valid, start;
  logic [31:0] wr_data, addr;

  logic        w_wr_ready, w_instr_valid, w_addr_err, w_full, w_wr_ovf, w_busy;
  logic [31:0] w_instruction;
  logic [3:0]  w_count;
  logic        b_wr_ready, b_instr_valid, b_addr_err, b_full, b_wr_ovf, b_busy;
  logic [31:0] b_instruction;
  logic [3:0]  b_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mq[$];
  logic        m_ovf;

  always #5 clk = ~clk;

  instr_mem_loader #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .BYTE_ADDR(1'b0), .NOP_WORD(NOP_W)) dut_w (
    .clk(clk), .rst(rst), .clr(clr), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(w_wr_ready),
    .start(start), .addr(addr), .instruction(w_instruction), .instr_valid(w_instr_valid),
    .addr_err(w_addr_err), .count(w_count), .full(w_full), .wr_ovf(w_wr_ovf), .busy(w_busy)
  );

  instr_mem_loader #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .BYTE_ADDR(1'b1), .NOP_WORD(NOP_B)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(b_wr_ready),
    .start(start), .addr(addr), .instruction(b_instruction), .instr_valid(b_instr_valid),
    .addr_err(b_addr_err), .count(b_count), .full(b_full), .wr_ovf(b_wr_ovf), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference fetch: word index is the address (or address/4), valid only below the fill level.
  function automatic void exp_fetch(input bit byte_mode, input logic [31:0] a,
                                    output logic [31:0] w, output logic e);
    int unsigned idx;
    idx = byte_mode ? (a / 4) : a;
    e = (byte_mode && (a % 4 != 0)) || (idx >= unsigned'(mq.size()));
    w = e ? (byte_mode ? NOP_B : NOP_W) : mq[idx];
  endfunction

  task automatic push_word(input logic [31:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    if (mq.size() < DEPTH) mq.push_back(d);
    else m_ovf = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while ((w_busy || b_busy) && n < 40);
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; clr = 1'b0; wr_valid = 1'b0; start = 1'b0; wr_data = '0; addr = '0;
    mq.delete(); m_ovf = 1'b0;
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if ({w_busy, w_wr_ready, w_count, w_full, w_wr_ovf, w_instr_valid, w_addr_err, w_instruction}
        !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, NOP_W}) begin
      $display("FAIL reset_w busy=%b rdy=%b cnt=%0d full=%b ovf=%b iv=%b err=%b ins=%h",
               w_busy, w_wr_ready, w_count, w_full, w_wr_ovf, w_instr_valid, w_addr_err, w_instruction);
    end else n_pass++;
    n_checks++;
    if ({b_busy, b_wr_ready, b_count, b_full, b_wr_ovf, b_instr_valid, b_addr_err, b_instruction}
        !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, NOP_B}) begin
      $display("FAIL reset_b busy=%b rdy=%b cnt=%0d ins=%h", b_busy, b_wr_ready, b_count, b_instruction);
    end else n_pass++;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    wait_clear(n);
    n_checks++;
    if (n != DEPTH) $display("FAIL clear_cycles got %0d want %0d", n, DEPTH);
    else n_pass++;
    n_checks++;
    if ({w_wr_ready, w_count, b_wr_ready, b_count} !== {1'b1, 4'd0, 1'b1, 4'd0})
      $display("FAIL after_clear rdy_w=%b cnt_w=%0d rdy_b=%b cnt_b=%0d want 1/0", w_wr_ready, w_count, b_wr_ready, b_count);
    else n_pass++;
  endtask

  task automatic test_fetch_sweep(input string tag);
    logic [31:0] al[$];
    logic [31:0] ew, eb;
    logic        ee, ebe;
    for (int i = 0; i < 4 * DEPTH + 4; i++) al.push_back(i);
    al.push_back(32'h0000_0100);
    al.push_back(32'hFFFF_FFFC);
    repeat (4) al.push_back($urandom());
    repeat (4) al.push_back($urandom_range(0, 40));
    start = 1'b1;
    tick();
    foreach (al[k]) begin
      addr = al[k];
      tick();
      exp_fetch(1'b0, al[k], ew, ee);
      exp_fetch(1'b1, al[k], eb, ebe);
      n_checks++;
      if ({w_instr_valid, w_addr_err, w_instruction} !== {1'b1, ee, ew})
        $display("FAIL %s_fetch_w addr=%h got iv=%b err=%b ins=%h want err=%b ins=%h",
                 tag, al[k], w_instr_valid, w_addr_err, w_instruction, ee, ew);
      else n_pass++;
      n_checks++;
      if ({b_instr_valid, b_addr_err, b_instruction} !== {1'b1, ebe, eb})
        $display("FAIL %s_fetch_b addr=%h got iv=%b err=%b ins=%h want err=%b ins=%h",
                 tag, al[k], b_instr_valid, b_addr_err, b_instruction, ebe, eb);
      else n_pass++;
    end
    start = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({w_instr_valid, w_addr_err, w_instruction, b_instr_valid, b_addr_err, b_instruction}
        !== {1'b0, 1'b0, NOP_W, 1'b0, 1'b0, NOP_B})
      $display("FAIL %s_idle got iv_w=%b err_w=%b ins_w=%h iv_b=%b ins_b=%h want invalid NOP",
               tag, w_instr_valid, w_addr_err, w_instruction, b_instr_valid, b_instruction);
    else n_pass++;
  endtask

  task automatic test_load_three();
    push_word(32'h11);
    push_word(32'h22);
    push_word(32'h33);
    n_checks++;
    if ({w_count, b_count, w_wr_ready} !== {4'd3, 4'd3, 1'b1})
      $display("FAIL load3_count got w=%0d b=%0d rdy=%b want 3/3/1", w_count, b_count, w_wr_ready);
    else n_pass++;
    test_fetch_sweep("load3");
  endtask

  task automatic test_run_stall_append();
    start = 1'b1;
    tick();
    wr_valid = 1'b1;
    wr_data  = 32'h44;
    repeat (3) tick();
    n_checks++;
    if ({w_wr_ready, w_count, b_wr_ready, b_count} !== {1'b0, 4'd3, 1'b0, 4'd3})
      $display("FAIL run_stall got rdy_w=%b cnt_w=%0d rdy_b=%b cnt_b=%0d want 0/3", w_wr_ready, w_count, b_wr_ready, b_count);
    else n_pass++;
    start = 1'b0;
    tick();
    tick();
    mq.push_back(32'h44);
    wr_valid = 1'b0;
    n_checks++;
    if ({w_count, b_count} !== {4'd4, 4'd4})
      $display("FAIL append_count got w=%0d b=%0d want 4", w_count, b_count);
    else n_pass++;
    test_fetch_sweep("append");
  endtask

  task automatic test_overflow();
    repeat (4) push_word($urandom());
    n_checks++;
    if ({w_count, w_full, w_wr_ready, w_wr_ovf, b_count, b_full} !== {4'd8, 1'b1, 1'b0, 1'b0, 4'd8, 1'b1})
      $display("FAIL fill got cnt=%0d full=%b rdy=%b ovf=%b want 8/1/0/0", w_count, w_full, w_wr_ready, w_wr_ovf);
    else n_pass++;
    push_word(32'hDEAD_BEEF);
    push_word(32'hCAFE_F00D);
    repeat (3) tick();
    n_checks++;
    if ({w_count, w_wr_ovf, b_count, b_wr_ovf} !== {4'd8, m_ovf, 4'd8, m_ovf})
      $display("FAIL ovf_sticky got cnt=%0d ovf_w=%b ovf_b=%b want 8/%b", w_count, w_wr_ovf, b_wr_ovf, m_ovf);
    else n_pass++;
    test_fetch_sweep("ovf");
  endtask

  task automatic test_clr_priority();
    int n;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    mq.delete(); m_ovf = 1'b0;
    n_checks++;
    if ({w_busy, w_count, w_wr_ovf, b_wr_ovf} !== {1'b1, 4'd0, 1'b0, 1'b0})
      $display("FAIL clr_state got busy=%b cnt=%0d ovf_w=%b ovf_b=%b want 1/0/0/0", w_busy, w_count, w_wr_ovf, b_wr_ovf);
    else n_pass++;
    wait_clear(n);
    push_word($urandom());
    push_word($urandom());
    clr = 1'b1; start = 1'b1; wr_valid = 1'b1; wr_data = 32'h5555_AAAA;
    tick();
    clr = 1'b0; start = 1'b0; wr_valid = 1'b0;
    mq.delete();
    n_checks++;
    if ({w_busy, w_count, w_wr_ready, b_busy, b_count} !== {1'b1, 4'd0, 1'b0, 1'b1, 4'd0})
      $display("FAIL clr_priority got busy=%b cnt=%0d rdy=%b b_cnt=%0d want 1/0/0/0", w_busy, w_count, w_wr_ready, b_count);
    else n_pass++;
    wait_clear(n);
    n_checks++;
    if (n != DEPTH) $display("FAIL clr_cycles got %0d want %0d", n, DEPTH);
    else n_pass++;
    test_fetch_sweep("clr");
  endtask

  task automatic test_random_rounds();
    int n, k;
    for (int r = 0; r < 3; r++) begin
      clr = 1'b1;
      tick();
      clr = 1'b0;
      mq.delete(); m_ovf = 1'b0;
      wait_clear(n);
      k = $urandom_range(1, DEPTH);
      for (int i = 0; i < k; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        push_word($urandom());
      end
      n_checks++;
      if ({w_count, b_count, w_full} !== {4'(mq.size()), 4'(mq.size()), (mq.size() == DEPTH)})
        $display("FAIL rand_count got w=%0d b=%0d full=%b want %0d", w_count, b_count, w_full, mq.size());
      else n_pass++;
      test_fetch_sweep("rand");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch_sweep("empty");
    test_load_three();
    test_run_stall_append();
    test_overflow();
    test_clr_priority();
    test_random_rounds();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
